// File: rtl/wb_hyperram_arbiter.sv
// Two-master Wishbone arbiter in front of the wb_hyperram slave: burst-locked
// ownership, round-robin on ties, and a watchdog that aborts unacknowledged strobes.
module wb_hyperram_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    output logic [31:0] s_addr_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e            state_q;
    logic              last_q;
    logic              owner_q;
    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;
    logic [1:0]        grant_q;
    logic [1:0]        err_q;
    logic              timeout_q;

    logic req0;
    logic req1;
    logic owner_cyc;
    logic stall;
    logic expire;

    assign req0      = m0_cyc_i & m0_stb_i;
    assign req1      = m1_cyc_i & m1_stb_i;
    assign owner_cyc = owner_q ? m1_cyc_i : m0_cyc_i;

    // Slave port follows the owning master combinationally; quiet otherwise.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_dat_o  = '0;
        s_addr_o = '0;
        case (state_q)
            OWN0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_dat_o  = m0_dat_i;
                s_addr_o = m0_addr_i;
            end
            OWN1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_dat_o  = m1_dat_i;
                s_addr_o = m1_addr_i;
            end
            default: ;
        endcase
    end

    // An ack in the expiry cycle clears the stall, so it always beats the abort.
    assign stall  = s_stb_o & ~s_ack_i;
    assign expire = owner_cyc & stall & (wdog_q == WDOG_LAST);
    assign wdog_d = (owner_cyc & stall & ~expire) ? wdog_q + WDOG_W'(1) : '0;

    assign m0_ack_o  = (state_q == OWN0) & s_ack_i;
    assign m1_ack_o  = (state_q == OWN1) & s_ack_i;
    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;
    assign m0_err_o  = err_q[0];
    assign m1_err_o  = err_q[1];
    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            wdog_q    <= '0;
            grant_q   <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            err_q  <= '0;
            wdog_q <= wdog_d;
            case (state_q)
                IDLE: begin
                    if (req0 && (!req1 || last_q)) begin
                        state_q <= OWN0;
                        owner_q <= 1'b0;
                        grant_q <= 2'b01;
                    end else if (req1) begin
                        state_q <= OWN1;
                        owner_q <= 1'b1;
                        grant_q <= 2'b10;
                    end
                end
                OWN0, OWN1: begin
                    if (!owner_cyc) begin
                        state_q <= IDLE;
                        last_q  <= owner_q;
                        grant_q <= '0;
                    end else if (expire) begin
                        state_q   <= DRAIN;
                        err_q     <= owner_q ? 2'b10 : 2'b01;
                        timeout_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Hold the grant until the aborted master gives up its cycle.
                    if (!owner_cyc) begin
                        state_q <= IDLE;
                        last_q  <= owner_q;
                        grant_q <= '0;
                    end
                end
            endcase
        end
    end

endmodule
